// File: rtl/instr_controller_if.sv
// Control bundle between the instruction controller and its datapath / issuer.
// The issuer (fetch unit or bench) presents instructions and start pulses;
// the controller drives the datapath strobes and decoded immediates.
interface instr_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        w;

  modport slave (
    input  in, load, s,
    output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           loadc, loads, shift, ALUop, sximm8, sximm5, w
  );

  modport master (
    output in, load, s,
    input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           loadc, loads, shift, ALUop, sximm8, sximm5, w
  );
endinterface

// File: rtl/instr_controller.sv
// Instruction register, field decode and Moore sequencer for the
// register/ALU datapath. One instruction runs per start pulse; w=1 when idle.
module instr_controller (
  input  logic                clk,
  input  logic                reset,
  instr_controller_if.slave   ctl
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_CMP, S_WR_RD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // Instruction fields
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic [4:0] opc_op;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];
  assign opc_op = {opcode, op};

  // Immediates are valid in every state, straight from IR
  assign ctl.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign ctl.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

  // IR only accepts a new word while idle, so a running instruction never changes
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && ctl.load) ir_d = ctl.in;
  end

  // State and instruction register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d      = state_q;
    ctl.readnum  = 3'd0;
    ctl.writenum = 3'd0;
    ctl.write    = 1'b0;
    ctl.vsel     = 4'b0000;
    ctl.loada    = 1'b0;
    ctl.loadb    = 1'b0;
    ctl.asel     = 1'b0;
    ctl.bsel     = 1'b0;
    ctl.loadc    = 1'b0;
    ctl.loads    = 1'b0;
    ctl.shift    = sh;
    ctl.ALUop    = 2'b00;
    ctl.w        = 1'b0;
    case (state_q)
      S_WAIT: begin
        ctl.w = 1'b1;
        if (ctl.s) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opc_op)
          5'b110_10:                    state_d = S_WR_IMM;
          5'b110_00:                    state_d = S_GET_B;
          5'b101_00, 5'b101_01,
          5'b101_10:                    state_d = S_GET_A;
          5'b101_11:                    state_d = S_GET_B;
          default:                      state_d = S_WAIT;
        endcase
      end
      S_WR_IMM: begin
        ctl.writenum = rn;
        ctl.vsel     = 4'b0010;
        ctl.write    = 1'b1;
        state_d      = S_WAIT;
      end
      S_GET_A: begin
        ctl.readnum = rn;
        ctl.loada   = 1'b1;
        state_d     = S_GET_B;
      end
      S_GET_B: begin
        ctl.readnum = rm;
        ctl.loadb   = 1'b1;
        state_d     = (opc_op == 5'b101_01) ? S_CMP : S_EXEC;
      end
      S_EXEC: begin
        // MOV reg passes B through an ADD with A forced to zero
        ctl.loadc = 1'b1;
        if (opc_op == 5'b110_00) begin
          ctl.asel  = 1'b1;
          ctl.ALUop = 2'b00;
        end else begin
          ctl.ALUop = op;
        end
        state_d = S_WR_RD;
      end
      S_CMP: begin
        ctl.ALUop = 2'b01;
        ctl.loads = 1'b1;
        state_d   = S_WAIT;
      end
      S_WR_RD: begin
        ctl.writenum = rd;
        ctl.vsel     = 4'b1000;
        ctl.write    = 1'b1;
        state_d      = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// Directed bench for instr_controller: runs each supported instruction,
// records the per-cycle strobe trace while busy, and checks it by hand values.
module tb_instr_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  instr_controller_if ctl();

  instr_controller dut (.clk(clk), .reset(reset), .ctl(ctl.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [3:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
  } cyc_t;

  cyc_t rec [0:15];
  int   n;
  int   nwrite, nloada, nloadc, nloads, nstrobe;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word (optionally loading it), pulse s, then record every busy cycle
  task automatic run(input logic [15:0] word, input bit do_load);
    ctl.in   = word;
    ctl.load = do_load;
    ctl.s    = 1'b1;
    step();
    ctl.load = 1'b0;
    ctl.s    = 1'b0;
    n = 0; nwrite = 0; nloada = 0; nloadc = 0; nloads = 0; nstrobe = 0;
    while (ctl.w == 1'b0 && n < 16) begin
      rec[n] = '{ctl.readnum, ctl.writenum, ctl.write, ctl.vsel, ctl.loada,
                 ctl.loadb, ctl.asel, ctl.loadc, ctl.loads, ctl.shift,
                 ctl.ALUop, ctl.sximm8};
      nwrite += int'(ctl.write);
      nloada += int'(ctl.loada);
      nloadc += int'(ctl.loadc);
      nloads += int'(ctl.loads);
      nstrobe += int'(ctl.write) + int'(ctl.loada) + int'(ctl.loadb) +
                 int'(ctl.loadc) + int'(ctl.loads) + int'(ctl.vsel != 4'b0);
      n++;
      step();
    end
  endtask

  initial begin
    ctl.in = 16'h0; ctl.load = 1'b0; ctl.s = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset / idle state
    chk("rst_w", 16'(ctl.w), 16'd1);
    chk("rst_write", 16'(ctl.write), 16'd0);
    chk("rst_vsel", 16'(ctl.vsel), 16'd0);
    chk("rst_readnum", 16'(ctl.readnum), 16'd0);
    chk("rst_writenum", 16'(ctl.writenum), 16'd0);
    chk("rst_ALUop", 16'(ctl.ALUop), 16'd0);
    chk("rst_sximm8", ctl.sximm8, 16'h0000);

    // MOV R0,#7
    run(16'hD007, 1'b1);
    chk("movi_lat", 16'(n), 16'd2);
    chk("movi_nwrite", 16'(nwrite), 16'd1);
    chk("movi_write", 16'(rec[1].write), 16'd1);
    chk("movi_writenum", 16'(rec[1].writenum), 16'd0);
    chk("movi_vsel", 16'(rec[1].vsel), 16'b0010);
    chk("movi_sximm8", rec[1].sximm8, 16'h0007);

    // ADD R2,R1,R0,LSL#1
    run(16'hA148, 1'b1);
    chk("add_lat", 16'(n), 16'd5);
    chk("add_loada", 16'(rec[1].loada), 16'd1);
    chk("add_rdA", 16'(rec[1].readnum), 16'd1);
    chk("add_loadb", 16'(rec[2].loadb), 16'd1);
    chk("add_rdB", 16'(rec[2].readnum), 16'd0);
    chk("add_loadc", 16'(rec[3].loadc), 16'd1);
    chk("add_ALUop", 16'(rec[3].ALUop), 16'b00);
    chk("add_asel", 16'(rec[3].asel), 16'd0);
    chk("add_shift", 16'(rec[3].shift), 16'b01);
    chk("add_write", 16'(rec[4].write), 16'd1);
    chk("add_writenum", 16'(rec[4].writenum), 16'd2);
    chk("add_vsel", 16'(rec[4].vsel), 16'b1000);
    chk("add_nloads", 16'(nloads), 16'd0);

    // CMP R1,R0
    run(16'hA900, 1'b1);
    chk("cmp_lat", 16'(n), 16'd4);
    chk("cmp_ALUop", 16'(rec[3].ALUop), 16'b01);
    chk("cmp_loads", 16'(rec[3].loads), 16'd1);
    chk("cmp_nloads", 16'(nloads), 16'd1);
    chk("cmp_nwrite", 16'(nwrite), 16'd0);
    chk("cmp_nloadc", 16'(nloadc), 16'd0);

    // MVN R3,R1
    run(16'hB861, 1'b1);
    chk("mvn_lat", 16'(n), 16'd4);
    chk("mvn_loadb", 16'(rec[1].loadb), 16'd1);
    chk("mvn_rdB", 16'(rec[1].readnum), 16'd1);
    chk("mvn_loadc", 16'(rec[2].loadc), 16'd1);
    chk("mvn_ALUop", 16'(rec[2].ALUop), 16'b11);
    chk("mvn_write", 16'(rec[3].write), 16'd1);
    chk("mvn_writenum", 16'(rec[3].writenum), 16'd3);
    chk("mvn_nloada", 16'(nloada), 16'd0);

    // MOV reg R2,R1 (asel forced)
    run(16'hC041, 1'b1);
    chk("movr_lat", 16'(n), 16'd4);
    chk("movr_asel", 16'(rec[2].asel), 16'd1);
    chk("movr_writenum", 16'(rec[3].writenum), 16'd2);

    // Sign extension, loading in WAIT without starting
    ctl.in = 16'hD0F8; ctl.load = 1'b1;
    step();
    ctl.load = 1'b0;
    chk("sx8_neg", ctl.sximm8, 16'hFFF8);
    chk("sx_idle_w", 16'(ctl.w), 16'd1);
    ctl.in = 16'hD01F; ctl.load = 1'b1;
    step();
    ctl.load = 1'b0;
    chk("sx5_neg", ctl.sximm5, 16'hFFFF);
    chk("sx8_pos", ctl.sximm8, 16'h001F);

    // Unsupported opcode
    run(16'h0000, 1'b1);
    chk("bad_lat", 16'(n), 16'd1);
    chk("bad_nstrobe", 16'(nstrobe), 16'd0);

    // s held high: w pulses high one cycle between instructions
    ctl.in = 16'hD007; ctl.load = 1'b1; ctl.s = 1'b1;
    step();
    ctl.load = 1'b0;
    chk("held_w0", 16'(ctl.w), 16'd0); step();
    chk("held_w1", 16'(ctl.w), 16'd0); step();
    chk("held_w2", 16'(ctl.w), 16'd1); step();
    chk("held_w3", 16'(ctl.w), 16'd0); step();
    chk("held_w4", 16'(ctl.w), 16'd0);
    ctl.s = 1'b0;
    step();
    chk("held_w5", 16'(ctl.w), 16'd1);

    // Reset during GET_B of ADD
    ctl.in = 16'hA148; ctl.load = 1'b1; ctl.s = 1'b1;
    step();                                  // DECODE
    ctl.load = 1'b0; ctl.s = 1'b0;
    step();                                  // GET_A
    step();                                  // GET_B
    chk("rmid_getb", 16'(ctl.loadb), 16'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_w", 16'(ctl.w), 16'd1);
    chk("rmid_write", 16'(ctl.write), 16'd0);
    step();
    chk("rmid_w2", 16'(ctl.w), 16'd1);
    chk("rmid_write2", 16'(ctl.write), 16'd0);

    // load while busy is ignored
    ctl.in = 16'hD007; ctl.load = 1'b1; ctl.s = 1'b1;
    step();                                  // DECODE
    ctl.s = 1'b0;
    ctl.in = 16'hD005;                       // load still high while busy
    step();                                  // WR_IMM
    ctl.load = 1'b0;
    chk("busy_write", 16'(ctl.write), 16'd1);
    chk("busy_sx8", ctl.sximm8, 16'h0007);
    step();                                  // WAIT
    chk("busy_w", 16'(ctl.w), 16'd1);
    run(16'hD005, 1'b0);
    chk("busy_lat", 16'(n), 16'd2);
    chk("busy_next_write", 16'(rec[1].write), 16'd1);
    chk("busy_next_sx8", rec[1].sximm8, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
